hv_wdg_reg_scan_ctrl: RTL and testbench

Watchdog register-scan sequencer. It periodically walks a contiguous register address window and issues one read per address through the watchdog-scan requester port of the register access arbiter. For each read it recomputes the CRC over the returned data and compares it with the stored CRC. Mismatches and ack timeouts are flagged to the watchdog/fault logic.

---
 rtl/hv_wdg_reg_scan_ctrl.sv | 155 +++++++++++++++
 tb/tb_hv_wdg_reg_scan_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hv_wdg_reg_scan_ctrl.sv
// hv_wdg_reg_scan_ctrl: periodic register-window scan with CRC-8 recheck and ack timeout.
// Define HV_WDG_SCAN_STOP_ON_ERR_EN to halt scanning on the first sticky error.
module hv_wdg_reg_scan_ctrl #(
   parameter int                 REG_AW     = 7,
   parameter int                 REG_DW     = 8,
   parameter int                 REG_CRC_W  = 8,
   parameter logic [REG_AW-1:0]  SCAN_START = 7'h00,
   parameter logic [REG_AW-1:0]  SCAN_END   = 7'h3F,
   parameter int                 GAP_CYC    = 16,
   parameter int                 PERIOD_CYC = 4096,
   parameter int                 ACK_TO     = 32
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_scan_en,
   input  logic                 i_err_clr,
   output logic                 o_wdg_scan_rac_rd_req,
   output logic [REG_AW-1:0]    o_wdg_scan_rac_addr,
   input  logic                 i_rac_wdg_scan_ack,
   input  logic [REG_DW-1:0]    i_rac_wdg_scan_data,
   input  logic [REG_CRC_W-1:0] i_rac_wdg_scan_crc,
   output logic                 o_scan_busy,
   output logic                 o_scan_done,
   output logic                 o_crc_err,
   output logic                 o_to_err,
   output logic [REG_AW-1:0]    o_err_addr
);
   localparam int PW = PERIOD_CYC > 1 ? $clog2(PERIOD_CYC) : 1;
   localparam int GW = $clog2(GAP_CYC + 1);
   localparam int TW = $clog2(ACK_TO + 1);

   typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_CHECK, ST_NEXT, ST_GAP, ST_HALT} state_t;

   state_t               r_state;
   logic [PW-1:0]        r_per;
   logic [GW-1:0]        r_gap_cnt;
   logic [TW-1:0]        r_to_cnt;
   logic [REG_AW-1:0]    r_addr;
   logic [REG_AW-1:0]    r_err_addr;
   logic [REG_DW-1:0]    r_data;
   logic [REG_CRC_W-1:0] r_crc;
   logic                 r_rd_req;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_crc_err;
   logic                 r_to_err;
   logic                 w_crc_set;
   logic                 w_to_set;

   function automatic logic [REG_CRC_W-1:0] f_crc(input logic [REG_DW-1:0] d);
      logic [REG_CRC_W-1:0] c;
      c = '0;
      for (int i = REG_DW - 1; i >= 0; i--)
         c = (c[REG_CRC_W-1] ^ d[i]) ? ((c << 1) ^ REG_CRC_W'(8'h07)) : (c << 1);
      return c;
   endfunction

   assign w_crc_set = (r_state == ST_CHECK) && (f_crc(r_data) != r_crc);
   assign w_to_set  = (r_state == ST_REQ) && !i_rac_wdg_scan_ack && (r_to_cnt == TW'(ACK_TO - 1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= ST_IDLE;
         r_per      <= '0;
         r_gap_cnt  <= '0;
         r_to_cnt   <= '0;
         r_addr     <= SCAN_START;
         r_err_addr <= '0;
         r_data     <= '0;
         r_crc      <= '0;
         r_rd_req   <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_crc_err  <= 1'b0;
         r_to_err   <= 1'b0;
      end else begin
         r_per     <= (!i_scan_en || r_per == PW'(PERIOD_CYC - 1)) ? '0 : r_per + 1'b1;
         r_done    <= 1'b0;
         r_crc_err <= w_crc_set | (r_crc_err & ~i_err_clr);
         r_to_err  <= w_to_set | (r_to_err & ~i_err_clr);
         // a clear coinciding with a new error still records that error as the first one
         if ((w_crc_set || w_to_set) && (!(r_crc_err || r_to_err) || i_err_clr))
            r_err_addr <= r_addr;
         else if (i_err_clr)
            r_err_addr <= '0;
         case (r_state)
            ST_IDLE:
               if (i_scan_en && r_per == '0) begin
                  r_state  <= ST_REQ;
                  r_rd_req <= 1'b1;
                  r_busy   <= 1'b1;
                  r_to_cnt <= '0;
               end
            ST_REQ:
               if (i_rac_wdg_scan_ack) begin
                  r_data   <= i_rac_wdg_scan_data;
                  r_crc    <= i_rac_wdg_scan_crc;
                  r_rd_req <= 1'b0;
                  r_state  <= ST_CHECK;
               end else if (w_to_set) begin
                  r_rd_req <= 1'b0;
                  r_state  <= ST_NEXT;
               end else begin
                  r_to_cnt <= r_to_cnt + 1'b1;
               end
            ST_CHECK:
               r_state <= ST_NEXT;
            ST_NEXT:
`ifdef HV_WDG_SCAN_STOP_ON_ERR_EN
               if (r_crc_err || r_to_err)
                  r_state <= ST_HALT;
               else
`endif
               if (!i_scan_en || r_addr == SCAN_END) begin
                  r_state <= ST_IDLE;
                  r_addr  <= SCAN_START;
                  r_busy  <= 1'b0;
                  r_done  <= i_scan_en;
               end else begin
                  r_addr    <= r_addr + 1'b1;
                  r_gap_cnt <= '0;
                  r_state   <= ST_GAP;
               end
            ST_GAP:
               if (!i_scan_en) begin
                  r_state <= ST_IDLE;
                  r_addr  <= SCAN_START;
                  r_busy  <= 1'b0;
               end else if (r_gap_cnt == GW'(GAP_CYC - 1)) begin
                  r_state  <= ST_REQ;
                  r_rd_req <= 1'b1;
                  r_to_cnt <= '0;
               end else begin
                  r_gap_cnt <= r_gap_cnt + 1'b1;
               end
            ST_HALT:
               if (i_err_clr) begin
                  r_state <= ST_IDLE;
                  r_addr  <= SCAN_START;
                  r_busy  <= 1'b0;
               end
            default:
               r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_wdg_scan_rac_rd_req = r_rd_req;
   assign o_wdg_scan_rac_addr   = r_addr;
   assign o_scan_busy           = r_busy;
   assign o_scan_done           = r_done;
   assign o_crc_err             = r_crc_err;
   assign o_to_err              = r_to_err;
   assign o_err_addr            = r_err_addr;
endmodule

// File: tb/tb_hv_wdg_reg_scan_ctrl.sv
// tb_hv_wdg_reg_scan_ctrl: directed bench for hv_wdg_reg_scan_ctrl over window 0x00..0x03.
module tb_hv_wdg_reg_scan_ctrl;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       scan_en = 1'b0;
   logic       err_clr = 1'b0;
   logic       rd_req;
   logic [6:0] addr;
   logic       ack = 1'b0;
   logic [7:0] data = 8'h00;
   logic [7:0] crcv = 8'h00;
   logic       busy, done, crc_err, to_err;
   logic [6:0] err_addr;

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         done_cnt = 0;
   int         ack_dly = 2;
   logic [6:0] hold_addr = 7'h7F;
   logic [6:0] bad_addr = 7'h7F;
   logic       late_ack = 1'b0;
   int         q_addr[$];
   int         q_cyc[$];
   int         q_len[$];

   hv_wdg_reg_scan_ctrl #(.SCAN_START(7'h00), .SCAN_END(7'h03)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_scan_en(scan_en), .i_err_clr(err_clr),
      .o_wdg_scan_rac_rd_req(rd_req), .o_wdg_scan_rac_addr(addr),
      .i_rac_wdg_scan_ack(ack), .i_rac_wdg_scan_data(data), .i_rac_wdg_scan_crc(crcv),
      .o_scan_busy(busy), .o_scan_done(done), .o_crc_err(crc_err), .o_to_err(to_err),
      .o_err_addr(err_addr));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
      end
   endtask

   // arbiter model: acks ack_dly cycles after req rise; CRC-8(0x5A)=0x81, bad entry 0x01 with 0x00
   initial begin
      int  rcnt;
      bit  prev;
      rcnt = 0;
      prev = 0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (done) done_cnt++;
         if (rd_req && !prev) begin
            q_addr.push_back(int'(addr));
            q_cyc.push_back(cyc);
            q_len.push_back(0);
            rcnt = 0;
         end
         ack  = late_ack;
         data = 8'h01;
         crcv = 8'h00;
         if (rd_req) begin
            rcnt++;
            q_len[q_len.size()-1] = rcnt;
            if (rcnt == ack_dly && addr != hold_addr) begin
               ack  = 1'b1;
               data = (addr == bad_addr) ? 8'h01 : 8'h5A;
               crcv = (addr == bad_addr) ? 8'h00 : 8'h81;
            end
         end
         prev = rd_req;
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_idle();
      for (int n = 0; n < 3000 && busy; n++) tick();
      chk("idle", int'(busy), 0);
   endtask

   task automatic sweep();
      q_addr.delete();
      q_cyc.delete();
      q_len.delete();
      scan_en = 1'b1;
      tick();
      tick();
      wait_idle();
      scan_en = 1'b0;
      tick();
   endtask

   task automatic clr();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
   endtask

   initial begin
      int d0;
      bit seen;
      repeat (3) tick();
      chk("rst_req", int'(rd_req), 0);
      chk("rst_addr", int'(addr), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_crc", int'(crc_err), 0);
      chk("rst_to", int'(to_err), 0);
      chk("rst_eaddr", int'(err_addr), 0);
      rst_n = 1'b1;
      tick();

      d0 = done_cnt;
      sweep();
      chk("t1_nreq", q_addr.size(), 4);
      for (int i = 0; i < 4; i++) chk("t1_addr", q_addr[i], i);
      for (int i = 0; i < 3; i++) chk("t1_space", q_cyc[i+1] - q_cyc[i], 20);
      chk("t1_len", q_len[0], 2);
      chk("t1_done", done_cnt - d0, 1);
      chk("t1_crc", int'(crc_err), 0);
      chk("t1_to", int'(to_err), 0);

`ifndef HV_WDG_SCAN_STOP_ON_ERR_EN
      bad_addr = 7'h02;
      sweep();
      chk("t2_nreq", q_addr.size(), 4);
      chk("t2_crc", int'(crc_err), 1);
      chk("t2_to", int'(to_err), 0);
      chk("t2_eaddr", int'(err_addr), 2);
      clr();
      chk("t2_clr_crc", int'(crc_err), 0);
      chk("t2_clr_eaddr", int'(err_addr), 0);
      bad_addr = 7'h7F;

      hold_addr = 7'h01;
      d0 = done_cnt;
      sweep();
      chk("t3_len", q_len[1], 32);
      chk("t3_to", int'(to_err), 1);
      chk("t3_crc", int'(crc_err), 0);
      chk("t3_eaddr", int'(err_addr), 1);
      chk("t3_next", q_addr[2], 2);
      chk("t3_done", done_cnt - d0, 1);
      clr();
      chk("t3_clr_to", int'(to_err), 0);
      hold_addr = 7'h7F;

      hold_addr = 7'h01;
      bad_addr  = 7'h03;
      q_addr.delete();
      scan_en = 1'b1;
      seen = 0;
      for (int n = 0; n < 400; n++) begin
         tick();
         if (rd_req && addr == 7'h03) seen = 1;
         if (seen && !rd_req) break;
      end
      chk("t6_check", int'(addr), 3);
      clr();
      chk("t6_crc", int'(crc_err), 1);
      chk("t6_to", int'(to_err), 0);
      chk("t6_eaddr", int'(err_addr), 3);
      wait_idle();
      scan_en = 1'b0;
      tick();
      clr();
      hold_addr = 7'h7F;
      bad_addr  = 7'h7F;
`else
      bad_addr = 7'h02;
      q_addr.delete();
      scan_en = 1'b1;
      repeat (300) tick();
      chk("h_busy", int'(busy), 1);
      chk("h_nreq", q_addr.size(), 3);
      chk("h_crc", int'(crc_err), 1);
      chk("h_eaddr", int'(err_addr), 2);
      scan_en = 1'b0;
      clr();
      tick();
      chk("h_idle", int'(busy), 0);
      bad_addr = 7'h7F;
`endif

      ack_dly = 10;
      d0 = done_cnt;
      sweep();
      chk("t4_len", q_len[0], 10);
      chk("t4_space", q_cyc[1] - q_cyc[0], 28);
      chk("t4_to", int'(to_err), 0);
      chk("t4_crc", int'(crc_err), 0);
      chk("t4_done", done_cnt - d0, 1);

      q_addr.delete();
      q_len.delete();
      d0 = done_cnt;
      scan_en = 1'b1;
      for (int n = 0; n < 400 && !(rd_req && addr == 7'h01); n++) tick();
      scan_en = 1'b0;
      wait_idle();
      chk("t5_nreq", q_addr.size(), 2);
      chk("t5_len", q_len[1], 10);
      chk("t5_to", int'(to_err), 0);
      chk("t5_done", done_cnt - d0, 0);
      chk("t5_addr", int'(addr), 0);
      sweep();
      chk("t5_restart", q_addr[0], 0);
      chk("t5_nreq2", q_addr.size(), 4);

      scan_en = 1'b1;
      for (int n = 0; n < 100 && !rd_req; n++) tick();
      tick();
      #1 rst_n = 1'b0;
      #1;
      chk("ar_req", int'(rd_req), 0);
      chk("ar_busy", int'(busy), 0);
      chk("ar_addr", int'(addr), 0);
      scan_en = 1'b0;
      tick();
      rst_n = 1'b1;
      late_ack = 1'b1;
      tick();
      tick();
      late_ack = 1'b0;
      repeat (4) tick();
      chk("late_req", int'(rd_req), 0);
      chk("late_busy", int'(busy), 0);
      chk("late_crc", int'(crc_err), 0);
      chk("late_to", int'(to_err), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
